branch_resolve_unit: RTL

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/bru_pkg.sv | 21 ++
 rtl/bru_pred_fifo.sv | 65 ++++++
 rtl/branch_resolve_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/bru_pkg.sv
// Branch resolve unit shared types: queue entry layout, FSM states, PC step.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bru_pkg;

   // Sequential next-PC increment for a not-taken branch.
   localparam logic [31:0] PC_STEP = 32'd4;

   // One in-flight prediction, as issued by fetch.
   typedef struct packed {
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
   } pred_entry_t;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } bru_state_e;

endpackage

// File: rtl/bru_pred_fifo.sv
// In-flight prediction queue: FIFO of pred_entry_t with synchronous flush.
// Latency: head_o shows the oldest entry combinationally; a push is visible one cycle later.
// Backpressure: push dropped when full unless a pop happens in the same cycle; flush beats push/pop.
//
// Ports: clk_i/rst_i (async active-high), push_i/push_dat_i, pop_i, flush_i,
//        head_o (oldest entry), full_o, empty_o.
module bru_pred_fifo
   import bru_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        push_i,
   input  pred_entry_t push_dat_i,
   input  logic        pop_i,
   input  logic        flush_i,
   output pred_entry_t head_o,
   output logic        full_o,
   output logic        empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   pred_entry_t mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          do_push, do_pop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];

   // Full-and-popping still accepts the push, so occupancy stays put.
   assign do_push = push_i & (~full_o | pop_i);
   assign do_pop  = pop_i & ~empty_o;

   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) begin
         mem_q[wr_ptr_q] <= push_dat_i;
      end
   end

   // DEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: matches execute-stage resolutions against queued predictions,
// strobes predictor updates and issues a one-cycle flush/redirect on mispredict.
// Latency: update/flush outputs one cycle after res_valid. Backpressure: pred_ready low when
// the queue is full (unless popping) or during FLUSH; stall freezes state and delays strobes.
//
// Ports: clk, rst (async active-high), stall; pred_valid/pred_pc/pred_taken/pred_target/pred_ready
//        from fetch; res_valid/res_taken/res_target from execute; upd_valid, Branch_direction,
//        PC_actual, PC_alu to predictor; rst_pipeline/redirect_pc to fetch; err_orphan sticky.
// Optional macro BRU_STATS_EN adds saturating stat_branches / stat_mispredicts counters.
module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        pred_valid,
   input  logic [31:0] pred_pc,
   input  logic        pred_taken,
   input  logic [31:0] pred_target,
   output logic        pred_ready,
   input  logic        res_valid,
   input  logic        res_taken,
   input  logic [31:0] res_target,
   output logic        upd_valid,
   output logic        Branch_direction,
   output logic [31:0] PC_actual,
   output logic [31:0] PC_alu,
   output logic        rst_pipeline,
   output logic [31:0] redirect_pc,
   output logic        err_orphan
`ifdef BRU_STATS_EN
   ,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispredicts
`endif
);

   bru_state_e  state_q, state_d;
   logic        upd_q, upd_d;
   logic        dir_q, dir_d;
   logic [31:0] pc_actual_q, pc_actual_d;
   logic [31:0] pc_alu_q, pc_alu_d;
   logic        orphan_q, orphan_d;

   pred_entry_t head, push_dat;
   logic        fifo_full, fifo_empty;
   logic        run, pop, push, mispredict, orphan_hit;

   assign run        = (state_q == ST_RUN);
   assign pop        = run & res_valid & ~stall & ~fifo_empty;
   assign orphan_hit = run & res_valid & ~stall & fifo_empty;
   assign mispredict = pop & ((head.taken != res_taken) |
                              (res_taken & (head.target != res_target)));
   assign pred_ready = run & (~fifo_full | pop);
   // A push racing the mispredicting pop belongs to the wrong path: drop it.
   assign push       = run & pred_valid & pred_ready & ~stall & ~mispredict;

   assign push_dat.pc     = pred_pc;
   assign push_dat.taken  = pred_taken;
   assign push_dat.target = pred_target;

   bru_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i      (clk),
      .rst_i      (rst),
      .push_i     (push),
      .push_dat_i (push_dat),
      .pop_i      (pop),
      .flush_i    (mispredict),
      .head_o     (head),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

   // Next-state and output-register logic; a stalled cycle holds everything,
   // so an already-registered strobe reappears once the stall lifts.
   always_comb begin
      state_d     = state_q;
      upd_d       = upd_q;
      dir_d       = dir_q;
      pc_actual_d = pc_actual_q;
      pc_alu_d    = pc_alu_q;
      orphan_d    = orphan_q | orphan_hit;
      if (!stall) begin
         upd_d = pop;
         if (pop) begin
            dir_d       = res_taken;
            pc_actual_d = res_taken ? res_target : (head.pc + PC_STEP);
            pc_alu_d    = res_target;
         end
         case (state_q)
            ST_RUN:   if (mispredict) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RUN;
         upd_q       <= 1'b0;
         dir_q       <= 1'b0;
         pc_actual_q <= '0;
         pc_alu_q    <= '0;
         orphan_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         upd_q       <= upd_d;
         dir_q       <= dir_d;
         pc_actual_q <= pc_actual_d;
         pc_alu_q    <= pc_alu_d;
         orphan_q    <= orphan_d;
      end
   end

   assign upd_valid        = upd_q & ~stall;
   assign rst_pipeline     = (state_q == ST_FLUSH) & ~stall;
   assign Branch_direction = dir_q;
   assign PC_actual        = pc_actual_q;
   assign PC_alu           = pc_alu_q;
   // The flush cycle coincides with the update strobe, so the redirect is the corrected PC.
   assign redirect_pc      = pc_actual_q;
   assign err_orphan       = orphan_q;

`ifdef BRU_STATS_EN
   logic [31:0] stat_br_q, stat_mis_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_br_q  <= '0;
         stat_mis_q <= '0;
      end else begin
         if (pop && stat_br_q != 32'hFFFF_FFFF)         stat_br_q  <= stat_br_q + 1'b1;
         if (mispredict && stat_mis_q != 32'hFFFF_FFFF) stat_mis_q <= stat_mis_q + 1'b1;
      end
   end

   assign stat_branches    = stat_br_q;
   assign stat_mispredicts = stat_mis_q;
`endif

endmodule
